fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction fetch stage placed between the PC/instruction-memory pair and the `mips_cpu` decode input. Owns the fetch PC, drives the combinational instruction memory address, and buffers fetched words with their PCs in a small prefetch FIFO. Delivers instructions to the core over a valid/ready handshake. Redirects (branch/jump) flush the queue and restart fetch from a new PC.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; power of two, 2..16.
- `RESET_PC`, 32'h0000_0000: fetch PC after reset; word-aligned.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `instruction_memory_a` out 32: fetch address. Equals the fetch PC; combinational from state.
- `instruction_memory_rd` in 32: instruction word at `instruction_memory_a`, valid in the same cycle.
- `redirect_valid` in 1: flush the queue and restart fetch.
- `redirect_pc` in 32: new fetch PC; bits [1:0] are ignored and forced to 0.
- `inst_valid` out 1: `inst`/`inst_pc` hold a valid entry.
- `inst_ready` in 1: consumer accepts the entry this cycle.
- `inst` out 32: instruction word at the queue head.
- `inst_pc` out 32: PC of `inst`.

## Operation
- State:
  - `fetch_pc` (32).
  - `count` (0..DEPTH).
  - head and tail pointers (log2 DEPTH bits, wrap modulo DEPTH).
  - Storage: DEPTH × {inst, pc}.
- Push: when `count < DEPTH` and no redirect, write {`instruction_memory_rd`, `fetch_pc`} at the tail. Advance the tail and set `fetch_pc <= fetch_pc + 4`.
- Full: when `count == DEPTH`, there is no push and `fetch_pc` holds. A pop in the same cycle does not enable a push that cycle; fetch resumes the next cycle.
- Pop: `inst_valid && inst_ready` advances the head.
- Count update: simultaneous push and pop leaves `count` unchanged.
- Redirect has priority over everything:
  - `count <= 0` and both pointers reset to 0.
  - `fetch_pc <= {redirect_pc[31:2], 2'b00}`.
  - No push that cycle.
  - A handshake in the redirect cycle counts as delivered to the consumer. The entry is discarded from the queue regardless.
- Outputs:
  - `inst_valid = (count != 0)`.
  - `inst`/`inst_pc` are the head entry when valid, otherwise 32'h0.
- Arithmetic: `fetch_pc + 4` is modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0.
- `inst_ready` while `inst_valid == 0` has no effect.
- Reset values:
  - `fetch_pc = RESET_PC`, `count = 0`, pointers 0.
  - `instruction_memory_a = RESET_PC`.
  - `inst_valid = 0`, `inst = 0`, `inst_pc = 0`.
  - Storage contents are don't-care.
- Reset mid-operation: all entries are dropped immediately (asynchronous). Fetch restarts at `RESET_PC` on the first edge after `rst_n` deasserts.

## Timing
- Fetch-to-deliver latency is 1 cycle. A word fetched in cycle N is at the head, with `inst_valid = 1`, in cycle N+1 if the queue was empty.
- Redirect asserted in cycle N:
  - Cycle N+1: `instruction_memory_a = redirect_pc`, `inst_valid = 0`.
  - Cycle N+2: first new instruction is valid.
- Throughput: 1 instruction/cycle sustained while `inst_ready` is held high.
- There are no combinational paths from `inst_ready` or `redirect_valid` to any output (except under the bypass option below).

## Configuration
- `FETCH_QUEUE_BYPASS_EN` defined:
  - Applies when `count == 0` and no redirect.
  - `inst_valid = 1`, `inst = instruction_memory_rd`, `inst_pc = fetch_pc`, combinationally.
  - If `inst_ready` is high, the word is consumed without a push and `fetch_pc` advances. Zero-latency delivery.
  - If `inst_ready` is low, the word is pushed normally.
- Not defined: bypass logic is absent; minimum latency is 1 cycle as above.

## Structure
- Shared package `fetch_pkg`:
  - `INST_W = 32`, `PC_STEP = 4`, `DEFAULT_RESET_PC`.
  - Typedef `fetch_entry_t` = {inst[31:0], pc[31:0]}.
- One sub-module `fetch_fifo`:
  - Parameterised synchronous FIFO of `fetch_entry_t` with push, pop and synchronous flush.
  - Exposes `count`, full and empty.
  - `fetch_queue` holds the PC logic, redirect priority and the bypass mux.

## Test plan
- Reset, then `inst_ready = 1` with memory word = address → `instruction_memory_a` sequence 0,4,8,...; `inst`/`inst_pc` pairs (0,0),(4,4),... one per cycle from cycle 1.
- `inst_ready = 0` for 10 cycles → `instruction_memory_a` stops at 16 with `count = 4`. Raise `inst_ready` → pops PCs 0,4,8,12 in order, fetch resumes at 16.
- Queue holding 3 entries, pulse `redirect_valid` with `redirect_pc = 32'h0000_0103` → next cycle `instruction_memory_a = 32'h100` and `inst_valid = 0`; following cycle `inst_pc = 32'h100`.
- Redirect to 32'hFFFF_FFF8 → fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert `rst_n = 0` mid-stream with 2 entries queued → `inst_valid` drops immediately; after release, fetch restarts at `RESET_PC`.
- With `FETCH_QUEUE_BYPASS_EN`, empty queue and `inst_ready = 1` → `inst == instruction_memory_rd` in the same cycle and `count` stays 0.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared constants and the queue entry type for the fetch
//               stage (fetch_queue / fetch_fifo).
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int          INST_W           = 32;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // One buffered fetch: the instruction word and the PC it was fetched from
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [31:0]       pc;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Power-of-two circular FIFO of fetch_entry_t with push, pop
//               and a synchronous flush that has priority over both.
//               Exposes occupancy count, full and empty.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  fetch_entry_t     i_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output fetch_entry_t     o_head,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  fetch_entry_t     r_mem [DEPTH];

  logic w_push;
  logic w_pop;

  // Requests are qualified here so callers cannot overflow/underflow the queue
  assign w_push = i_push && !o_full  && !i_flush;
  assign w_pop  = i_pop  && !o_empty && !i_flush;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  // Entry storage; contents are meaningless while not counted, so no reset
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= i_data;
  end

  assign o_head  = r_mem[r_head];
  assign o_count = r_count;
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Instruction fetch stage. Owns the fetch PC, drives the
//               instruction memory address and buffers {inst, pc} pairs in
//               fetch_fifo for delivery over a valid/ready handshake.
//               Redirects flush the queue and restart fetch.
//               Optional macro FETCH_QUEUE_BYPASS_EN: zero-latency delivery
//               of the memory word while the queue is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [31:0]       instruction_memory_a,
  input  logic [INST_W-1:0] instruction_memory_rd,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [31:0]       inst_pc
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      r_fetch_pc;
  logic [31:0]      w_redirect_pc;
  fetch_entry_t     w_push_data;
  fetch_entry_t     w_head;
  logic [CNT_W-1:0] w_count;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_advance;
  logic             w_bypass;

  // Redirect targets are always word-aligned
  assign w_redirect_pc = redirect_pc & ~32'h3;

  assign instruction_memory_a = r_fetch_pc;
  assign w_push_data          = '{inst: instruction_memory_rd, pc: r_fetch_pc};

`ifdef FETCH_QUEUE_BYPASS_EN
  // Empty queue: present the memory word directly; consume it if ready
  assign w_bypass   = w_empty && !redirect_valid;
  assign inst_valid = !w_empty || w_bypass;
  assign w_push     = !redirect_valid && !w_full && !(w_bypass && inst_ready);
  assign w_advance  = w_push || (w_bypass && inst_ready);
`else
  assign w_bypass   = 1'b0;
  assign inst_valid = !w_empty;
  // A pop while full does not free a slot until the next cycle
  assign w_push     = !redirect_valid && !w_full;
  assign w_advance  = w_push;
`endif

  // Pop only real queue entries; a bypassed word never enters the FIFO
  assign w_pop = inst_ready && !w_empty;

  // Output mux: queue head, else the bypassed memory word, else zero
  always_comb begin
    inst    = '0;
    inst_pc = '0;
    if (w_count != '0) begin
      inst    = w_head.inst;
      inst_pc = w_head.pc;
    end else if (w_bypass) begin
      inst    = instruction_memory_rd;
      inst_pc = r_fetch_pc;
    end
  end

  // Fetch PC: redirect wins, otherwise step past each word taken from memory
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_fetch_pc <= w_redirect_pc;
    end else if (w_advance) begin
      r_fetch_pc <= r_fetch_pc + PC_STEP;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue
// Description : Self-checking bench for fetch_queue. Instruction memory is
//               modelled as word == address. A table of per-cycle vectors
//               covers fill/full/drain/redirect; hand sequences cover async
//               reset, address wrap and the empty-queue redirect restart.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_ready = 1'b0;
  logic [31:0] instruction_memory_a;
  logic [31:0] instruction_memory_rd;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Memory model: the word stored at each address is the address itself
  assign instruction_memory_rd = instruction_memory_a;

  fetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .instruction_memory_a  (instruction_memory_a),
    .instruction_memory_rd (instruction_memory_rd),
    .redirect_valid        (redirect_valid),
    .redirect_pc           (redirect_pc),
    .inst_valid            (inst_valid),
    .inst_ready            (inst_ready),
    .inst                  (inst),
    .inst_pc               (inst_pc)
  );

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic [31:0] a;
    logic        v;
    logic [31:0] i;
    logic [31:0] p;
    logic        emp;   // queue empty this cycle (bypass build shows the memory word)
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare all outputs; in the bypass build an empty queue shows {rd, fetch_pc}
  task automatic chk_out(input string tag, input logic [31:0] a, input logic v,
                         input logic [31:0] i, input logic [31:0] p, input logic emp);
    logic        ev;
    logic [31:0] ei;
    logic [31:0] ep;
    ev = v;
    ei = i;
    ep = p;
`ifdef FETCH_QUEUE_BYPASS_EN
    if (emp) begin
      ev = 1'b1;
      ei = a;
      ep = a;
    end
`endif
    chk({tag, ".addr"},  instruction_memory_a, a);
    chk({tag, ".valid"}, {31'b0, inst_valid},  {31'b0, ev});
    chk({tag, ".inst"},  inst,                 ei);
    chk({tag, ".pc"},    inst_pc,              ep);
  endtask

  task automatic cyc(input logic redir, input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    redirect_valid = redir;
    redirect_pc    = rpc;
    inst_ready     = rdy;
    #1;
  endtask

  initial begin
    // redir, rpc, rdy | addr, valid, inst, pc | empty
    tbl[0]  = '{1'b0, 32'h0,   1'b0, 32'd0,   1'b0, 32'd0,   32'd0,   1'b1};
    tbl[1]  = '{1'b0, 32'h0,   1'b0, 32'd4,   1'b1, 32'd0,   32'd0,   1'b0};
    tbl[2]  = '{1'b0, 32'h0,   1'b0, 32'd8,   1'b1, 32'd0,   32'd0,   1'b0};
    tbl[3]  = '{1'b0, 32'h0,   1'b0, 32'd12,  1'b1, 32'd0,   32'd0,   1'b0};
    tbl[4]  = '{1'b0, 32'h0,   1'b0, 32'd16,  1'b1, 32'd0,   32'd0,   1'b0};
    tbl[5]  = '{1'b0, 32'h0,   1'b0, 32'd16,  1'b1, 32'd0,   32'd0,   1'b0};
    tbl[6]  = '{1'b0, 32'h0,   1'b1, 32'd16,  1'b1, 32'd0,   32'd0,   1'b0};
    tbl[7]  = '{1'b0, 32'h0,   1'b1, 32'd16,  1'b1, 32'd4,   32'd4,   1'b0};
    tbl[8]  = '{1'b0, 32'h0,   1'b1, 32'd20,  1'b1, 32'd8,   32'd8,   1'b0};
    tbl[9]  = '{1'b0, 32'h0,   1'b1, 32'd24,  1'b1, 32'd12,  32'd12,  1'b0};
    tbl[10] = '{1'b0, 32'h0,   1'b1, 32'd28,  1'b1, 32'd16,  32'd16,  1'b0};
    tbl[11] = '{1'b0, 32'h0,   1'b1, 32'd32,  1'b1, 32'd20,  32'd20,  1'b0};
    tbl[12] = '{1'b1, 32'h103, 1'b0, 32'd36,  1'b1, 32'd24,  32'd24,  1'b0};
    tbl[13] = '{1'b0, 32'h0,   1'b0, 32'h100, 1'b0, 32'h0,   32'h0,   1'b1};
    tbl[14] = '{1'b0, 32'h0,   1'b0, 32'h104, 1'b1, 32'h100, 32'h100, 1'b0};

    // Reset state while rst_n is held low
    @(negedge clk);
    #1;
    chk_out("reset", 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Fill to full with ready low, drain with ready high, then redirect
    for (int k = 0; k < 15; k++) begin
      cyc(tbl[k].redir, tbl[k].rpc, tbl[k].rdy);
      chk_out($sformatf("vec%0d", k), tbl[k].a, tbl[k].v, tbl[k].i, tbl[k].p, tbl[k].emp);
    end

    // Async reset with two entries queued: outputs drop without a clock edge
    cyc(1'b0, 32'h0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    cyc(1'b0, 32'h0, 1'b0);
    chk_out("rst_rel0", 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    cyc(1'b1, 32'hFFFF_FFF8, 1'b1);
    chk_out("rst_rel1", 32'h4, 1'b1, 32'h0, 32'h0, 1'b0);

    // Redirect near the top of the address space: fetch wraps to zero
    cyc(1'b0, 32'h0, 1'b0);
    chk_out("wrap0", 32'hFFFF_FFF8, 1'b0, 32'h0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b1);
    chk_out("wrap1", 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 1'b0);
    cyc(1'b0, 32'h0, 1'b1);
    chk_out("wrap2", 32'h0000_0000, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
    cyc(1'b1, 32'h200, 1'b0);
    chk_out("wrap3", 32'h0000_0004, 1'b1, 32'h0, 32'h0, 1'b0);

    // Empty queue after redirect with ready high: the bypass build consumes
    // the word at once, the default build queues it for the next cycle
    cyc(1'b0, 32'h0, 1'b1);
    chk_out("restart0", 32'h200, 1'b0, 32'h0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0);
`ifdef FETCH_QUEUE_BYPASS_EN
    chk_out("restart1", 32'h204, 1'b1, 32'h204, 32'h204, 1'b1);
`else
    chk_out("restart1", 32'h204, 1'b1, 32'h200, 32'h200, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls
  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
